col_input_ctrl: RTL and testbench

COL_INPUT_CTRL -- requirements
Module: col_input_ctrl

---
 rtl/col_input_ctrl.sv | 67 ++++++
 tb/tb_col_input_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/col_input_ctrl.sv
// col_input_ctrl: buffers ROWS operand words and loads them into a PE column; COL_IN_SKEW_EN staggers the row strobes
module col_input_ctrl #(
  parameter int ROWS = 8,
  parameter int INWIDTH = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [INWIDTH-1:0] in_w,
  input  logic               wvalid,
  output logic               wready,
  input  logic               go,
  input  logic               clear,
  output logic [INWIDTH-1:0] out_r [0:ROWS-1],
  output logic               out_v [0:ROWS-1],
  output logic               armed
);
  localparam int IW = $clog2(ROWS + 1);
  localparam int OW = $clog2(ROWS);
  typedef enum logic [1:0] {FILL, ARMED, ISSUE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] icnt;
  logic [INWIDTH-1:0] buf_q [0:ROWS-1];
  logic xfer, last_w, issue_done;
  assign xfer = wvalid && wready;
  assign last_w = icnt == IW'(ROWS - 1);
  assign out_r = buf_q;
`ifdef COL_IN_SKEW_EN
  logic [OW-1:0] ocnt;
  assign issue_done = ocnt == OW'(ROWS - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ocnt <= '0;
    else if (clear || (state == ARMED && go)) ocnt <= '0;
    else if (state == ISSUE) ocnt <= ocnt + 1'b1;
`else
  assign issue_done = 1'b1;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= FILL;
    else state <= state_nx;
  always_comb begin
    state_nx = clear ? FILL :
               state == FILL  ? ((xfer && last_w) ? ARMED : FILL) :
               state == ARMED ? (go ? ISSUE : ARMED) :
               issue_done ? FILL : ISSUE;
  end
  always_comb begin
    wready = state == FILL;
    armed = state == ARMED;
    for (int i = 0; i < ROWS; i++)
`ifdef COL_IN_SKEW_EN
      out_v[i] = state == ISSUE && ocnt == OW'(i);
`else
      out_v[i] = state == ISSUE;
`endif
  end
  // buf only moves on accepted transfers, so out_r holds steady through ISSUE
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      icnt <= '0;
      for (int i = 0; i < ROWS; i++) buf_q[i] <= '0;
    end else if (clear || (state == ISSUE && issue_done)) begin
      icnt <= '0;
    end else if (xfer) begin
      buf_q[icnt[OW-1:0]] <= in_w;
      icnt <= icnt + 1'b1;
    end
endmodule

// File: tb/tb_col_input_ctrl.sv
// tb_col_input_ctrl: directed self-checking bench for col_input_ctrl
module tb_col_input_ctrl;
  localparam int ROWS = 8;
  localparam int W = 32;
  logic clk = 1'b0, rstn = 1'b0, wvalid = 1'b0, go = 1'b0, clear = 1'b0;
  logic [W-1:0] in_w = '0;
  logic wready, armed;
  logic [W-1:0] out_r [0:ROWS-1];
  logic out_v [0:ROWS-1];
  logic [ROWS-1:0] ovec;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  col_input_ctrl #(.ROWS(ROWS), .INWIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .in_w(in_w), .wvalid(wvalid), .wready(wready),
    .go(go), .clear(clear), .out_r(out_r), .out_v(out_v), .armed(armed)
  );
  always_comb for (int i = 0; i < ROWS; i++) ovec[i] = out_v[i];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [W-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      wvalid = 1'b1;
      in_w = base + W'(k);
      tick();
    end
    wvalid = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_wready", wready, 1);
    chk("rst_armed", armed, 0);
    chk("rst_out_v", ovec, 0);
    chk("rst_out_r0", out_r[0], 0);
    chk("rst_out_r7", out_r[7], 0);
    #10 rstn = 1'b1;
    tick();
    fill(32'h10, 7);
    chk("fill7_armed", armed, 0);
    chk("fill7_wready", wready, 1);
    fill(32'h17, 1);
    chk("fill8_armed", armed, 1);
    chk("fill8_wready", wready, 0);
    for (int k = 0; k < ROWS; k++) chk($sformatf("buf%0d", k), out_r[k], 32'h10 + k);
    wvalid = 1'b1;
    in_w = 32'hdead;
    tick();
    wvalid = 1'b0;
    chk("armed_ignore_w_armed", armed, 1);
    chk("armed_ignore_w_buf0", out_r[0], 32'h10);
    chk("armed_out_v", ovec, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
`ifdef COL_IN_SKEW_EN
    for (int k = 0; k < ROWS; k++) begin
      chk($sformatf("skew_v%0d", k), ovec, 8'b1 << k);
      chk($sformatf("skew_r%0d", k), out_r[k], 32'h10 + k);
      chk($sformatf("skew_wready%0d", k), wready, 0);
      tick();
    end
`else
    chk("issue_all_v", ovec, 8'hff);
    chk("issue_wready", wready, 0);
    chk("issue_r3", out_r[3], 32'h13);
    tick();
`endif
    chk("post_issue_wready", wready, 1);
    chk("post_issue_v", ovec, 0);
    chk("post_issue_armed", armed, 0);
    fill(32'h20, 5);
    wvalid = 1'b1;
    in_w = 32'h99;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    fill(32'h30, 5);
    chk("clr_buf0", out_r[0], 32'h30);
    chk("clr_buf4", out_r[4], 32'h34);
    chk("clr_buf5_kept", out_r[5], 32'h15);
    chk("clr_armed", armed, 0);
    fill(32'h35, 3);
    chk("clr_refill_armed", armed, 1);
    chk("clr_buf7", out_r[7], 32'h37);
    go = 1'b1;
    tick();
    go = 1'b0;
`ifdef COL_IN_SKEW_EN
    tick();
    tick();
    tick();
    chk("pre_rst_v3", ovec, 8'h08);
`else
    chk("pre_rst_v", ovec, 8'hff);
`endif
    rstn = 1'b0;
    #1;
    chk("midrst_v", ovec, 0);
    chk("midrst_r0", out_r[0], 0);
    chk("midrst_r3", out_r[3], 0);
    chk("midrst_wready", wready, 1);
    #5 rstn = 1'b1;
    tick();
    chk("postrst_v", ovec, 0);
    chk("postrst_wready", wready, 1);
    go = 1'b1;
    fill(32'h40, 7);
    chk("gofill_v", ovec, 0);
    chk("gofill_armed", armed, 0);
    fill(32'h47, 1);
    chk("gofill_armed8", armed, 1);
    chk("gofill_v8", ovec, 0);
    tick();
    go = 1'b0;
`ifdef COL_IN_SKEW_EN
    chk("gofill_issue_v", ovec, 8'h01);
    repeat (ROWS) tick();
`else
    chk("gofill_issue_v", ovec, 8'hff);
    tick();
`endif
    chk("gofill_done_wready", wready, 1);
    chk("gofill_done_v", ovec, 0);
    chk("gofill_buf0", out_r[0], 32'h40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
